// File: rtl/codec_cfg_sequencer_if.sv
// Go/done handshake between the codec configuration sequencer and the I2C serialiser.
interface codec_cfg_sequencer_if;
    logic        i2c_go;
    logic [23:0] i2c_data;
    logic        i2c_done;
    logic        i2c_ack_ok;

    modport master (output i2c_go, output i2c_data, input i2c_done, input i2c_ack_ok);
    modport slave  (input i2c_go, input i2c_data, output i2c_done, output i2c_ack_ok);
endinterface

// File: rtl/codec_cfg_sequencer.sv
// WM8731 register-load sequencer: settle, walk the config table, then rewrite volume on request.
// Optional per-word retry on NACK/timeout is enabled by defining CODEC_CFG_RETRY_EN.
module codec_cfg_sequencer #(
    parameter int unsigned ROM_DEPTH   = 12,
    parameter logic [7:0]  DEV_ADDR    = 8'h34,
    parameter int unsigned SETTLE_LOG2 = 10,
    parameter int unsigned TIMEOUT     = 4096,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    codec_cfg_sequencer_if.master        i2c,
    input  logic [6:0]                   vol,
    input  logic                         vol_update,
    output logic                         cfg_busy,
    output logic                         cfg_done,
    output logic                         cfg_error,
    output logic [5:0]                   err_index
);

    localparam int unsigned TMO_W    = $clog2(TIMEOUT);
    localparam logic [5:0]  LAST_IDX = 6'(ROM_DEPTH - 1);
    localparam logic [5:0]  VOL_IDX  = 6'd9;
    localparam logic [5:0]  VOL_LAST = 6'd10;

    if (ROM_DEPTH < 12 || ROM_DEPTH > 64 || SETTLE_LOG2 < 1 || TIMEOUT < 2 || MAX_RETRY > 255)
    begin : g_param_check
        $error("codec_cfg_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_SETTLE, ST_LOAD, ST_ISSUE, ST_WAIT, ST_NEXT, ST_DONE, ST_FAIL, ST_ERROR
    } state_e;

    state_e                 state_q;
    logic [SETTLE_LOG2-1:0] settle_q;
    logic [TMO_W-1:0]       tmo_q;
    logic [5:0]             index_q;
    logic                   update_q;
    logic                   pend_q;
    logic                   go_q;
    logic [23:0]            data_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;
    logic [5:0]             err_idx_q;
    logic [15:0]            rom_val_d;

`ifdef CODEC_CFG_RETRY_EN
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
    logic [RETRY_W-1:0] retry_q;
`endif

    // Volume entries sample vol at LOAD time, so the table is combinational on index and vol.
    always_comb begin
        // NOTE: default first so every path assigns rom_val_d and no latch is inferred.
        rom_val_d = 16'h0000;
        case (index_q)
            6'd0:    rom_val_d = 16'h1E00;
            6'd1:    rom_val_d = 16'h1200;
            6'd2:    rom_val_d = 16'h0C00;
            6'd3:    rom_val_d = 16'h0217;
            6'd4:    rom_val_d = 16'h0812;
            6'd5:    rom_val_d = 16'h0A00;
            6'd6:    rom_val_d = 16'h0017;
            6'd7:    rom_val_d = 16'h0E42;
            6'd8:    rom_val_d = 16'h101C;
            6'd9:    rom_val_d = {7'h02, 2'b00, vol};
            6'd10:   rom_val_d = {7'h03, 2'b00, vol};
            6'd11:   rom_val_d = 16'h1201;
            default: rom_val_d = 16'h0000;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_SETTLE;
            settle_q  <= '0;
            tmo_q     <= '0;
            index_q   <= '0;
            update_q  <= 1'b0;
            pend_q    <= 1'b0;
            go_q      <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
`ifdef CODEC_CFG_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout; later assignments in this block override the defaults.
            go_q <= 1'b0;
            if (vol_update && state_q != ST_ERROR) pend_q <= 1'b1;

            case (state_q)
                ST_SETTLE: begin
                    if (settle_q == '1) begin
                        index_q <= '0;
                        state_q <= ST_LOAD;
                    end else begin
                        settle_q <= settle_q + SETTLE_LOG2'(1);
                    end
                end
                ST_LOAD: begin
                    data_q  <= {DEV_ADDR, rom_val_d};
                    busy_q  <= 1'b1;
                    state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    go_q    <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i2c.i2c_done) begin
                        state_q <= i2c.i2c_ack_ok ? ST_NEXT : ST_FAIL;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        state_q <= ST_FAIL;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_NEXT: begin
                    index_q <= index_q + 6'd1;
`ifdef CODEC_CFG_RETRY_EN
                    retry_q <= '0;
`endif
                    if (index_q == (update_q ? VOL_LAST : LAST_IDX)) begin
                        if (!update_q) done_q <= 1'b1;
                        update_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end else begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    // A request arriving in this very cycle is taken directly.
                    if (pend_q || vol_update) begin
                        pend_q   <= 1'b0;
                        index_q  <= VOL_IDX;
                        update_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_LOAD;
                    end
                end
                ST_FAIL: begin
`ifdef CODEC_CFG_RETRY_EN
                    retry_q <= retry_q + RETRY_W'(1);
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        state_q <= ST_LOAD;
                    end else begin
                        error_q   <= 1'b1;
                        err_idx_q <= index_q;
                        busy_q    <= 1'b0;
                        state_q   <= ST_ERROR;
                    end
`else
                    error_q   <= 1'b1;
                    err_idx_q <= index_q;
                    busy_q    <= 1'b0;
                    state_q   <= ST_ERROR;
`endif
                end
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end
            endcase
        end
    end

    assign i2c.i2c_go   = go_q;
    assign i2c.i2c_data = data_q;
    assign cfg_busy     = busy_q;
    assign cfg_done     = done_q;
    assign cfg_error    = error_q;
    assign err_index    = err_idx_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer: serialiser model, expected-transfer queue and status checks.
module tb_codec_cfg_sequencer;

    localparam int ROM_DEPTH   = 12;
    localparam int SETTLE_LOG2 = 4;
    localparam int TIMEOUT     = 64;
    localparam int MAX_RETRY   = 3;
    localparam int SER_DELAY   = 20;

    localparam logic [15:0] TABLE [12] = '{
        16'h1E00, 16'h1200, 16'h0C00, 16'h0217, 16'h0812, 16'h0A00,
        16'h0017, 16'h0E42, 16'h101C, 16'h0400, 16'h0600, 16'h1201
    };

    typedef struct {
        int          idx;
        logic [23:0] word;
    } xfer_t;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic [6:0] vol = 7'h00;
    logic       vol_update = 1'b0;
    logic       cfg_busy, cfg_done, cfg_error;
    logic [5:0] err_index;

    codec_cfg_sequencer_if bus ();

    codec_cfg_sequencer #(
        .ROM_DEPTH  (ROM_DEPTH),
        .DEV_ADDR   (8'h34),
        .SETTLE_LOG2(SETTLE_LOG2),
        .TIMEOUT    (TIMEOUT),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .i2c       (bus.master),
        .vol       (vol),
        .vol_update(vol_update),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .err_index (err_index)
    );

    initial forever #5 CLOCK = ~CLOCK;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          go_cnt = 0;
    int          first_go_cyc = -1;
    xfer_t       exp_q[$];
    logic [23:0] word_log[$];
    int          nack_left[64];
    bit          ser_busy = 1'b0;
    bit          ser_silent = 1'b0;
    bit          stray_req = 1'b0;
    int          ser_cnt = 0;
    int          ser_idx = 0;
    logic [23:0] ser_word = '0;

    always @(posedge CLOCK) cyc <= RESET ? cyc + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected word straight from the register table; volume entries carry vol in the low bits.
    function automatic logic [23:0] exp_word(input int idx, input logic [6:0] v);
        logic [15:0] val;
        val = (idx < 12) ? TABLE[idx] : 16'h0000;
        if (idx == 9 || idx == 10) val = val | {9'd0, v};
        return {8'h34, val};
    endfunction

    task automatic push_range(input int lo, input int hi, input logic [6:0] v);
        xfer_t e;
        for (int i = lo; i <= hi; i++) begin
            e.idx  = i;
            e.word = exp_word(i, v);
            exp_q.push_back(e);
        end
    endtask

    // Serialiser model and per-cycle compare against the expected-transfer queue.
    initial begin
        xfer_t e;
        bus.i2c_done   = 1'b0;
        bus.i2c_ack_ok = 1'b0;
        forever begin
            @(negedge CLOCK);
            bus.i2c_done   = 1'b0;
            bus.i2c_ack_ok = 1'b0;
            if (!RESET) begin
                ser_busy = 1'b0;
            end else begin
                if (ser_busy) begin
                    check("data_stable", bus.i2c_data, ser_word);
                    if (!ser_silent) begin
                        check("busy_in_xfer", cfg_busy, 1);
                        ser_cnt--;
                        if (ser_cnt == 0) begin
                            bus.i2c_done = 1'b1;
                            if (nack_left[ser_idx] > 0) begin
                                nack_left[ser_idx]--;
                                bus.i2c_ack_ok = 1'b0;
                            end else begin
                                bus.i2c_ack_ok = 1'b1;
                            end
                            ser_busy = 1'b0;
                        end
                    end
                end else if (stray_req) begin
                    bus.i2c_done   = 1'b1;
                    bus.i2c_ack_ok = 1'b0;
                    stray_req      = 1'b0;
                end
                if (bus.i2c_go === 1'b1) begin
                    go_cnt++;
                    if (first_go_cyc < 0) first_go_cyc = cyc;
                    word_log.push_back(bus.i2c_data);
                    if (!ser_silent) check("go_while_busy", ser_busy, 0);
                    check("go_expected", exp_q.size() > 0, 1);
                    ser_idx = 0;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("word_idx%0d", e.idx), bus.i2c_data, e.word);
                        ser_idx = e.idx;
                    end
                    ser_busy = 1'b1;
                    ser_cnt  = SER_DELAY;
                    ser_word = bus.i2c_data;
                end
            end
        end
    end

    task automatic start_run();
        @(negedge CLOCK);
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK);
        exp_q.delete();
        word_log.delete();
        go_cnt       = 0;
        first_go_cyc = -1;
        ser_silent   = 1'b0;
        for (int i = 0; i < 64; i++) nack_left[i] = 0;
        RESET = 1'b1;
    endtask

    task automatic pulse_update();
        @(negedge CLOCK);
        vol_update = 1'b1;
        @(negedge CLOCK);
        vol_update = 1'b0;
    endtask

    task automatic wait_go(input int n, input int limit, input string name);
        int k = 0;
        while (go_cnt < n && k < limit) begin
            @(negedge CLOCK);
            k++;
        end
        check(name, go_cnt >= n, 1);
    endtask

    task automatic wait_status(input bit want_err, input int limit, input string name);
        int k = 0;
        while ((want_err ? cfg_error : cfg_done) !== 1'b1 && k < limit) begin
            @(negedge CLOCK);
            k++;
        end
        check(name, want_err ? cfg_error : cfg_done, 1);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k = 0;
        bit ok = 1'b0;
        while (!ok && k < limit) begin
            @(negedge CLOCK);
            k++;
            ok = (exp_q.size() == 0) && !ser_busy && (cfg_busy === 1'b0);
        end
        check(name, ok, 1);
    endtask

    initial begin
        int go_edge;
        int n_w4;

        // Reset values.
        #2 RESET = 1'b0;
        #2;
        check("rst_go", bus.i2c_go, 0);
        check("rst_data", bus.i2c_data, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_done", cfg_done, 0);
        check("rst_error", cfg_error, 0);
        check("rst_err_index", err_index, 0);

        // Initial load; three vol_update pulses during it collapse into one update after DONE.
        vol = 7'h79;
        start_run();
        push_range(0, 11, 7'h79);
        push_range(9, 10, 7'h79);
        wait_go(3, 500, "load_go3");
        pulse_update();
        repeat (2) @(negedge CLOCK);
        pulse_update();
        pulse_update();
        wait_status(1'b0, 2000, "load_done_seen");
        check("load_go_count", go_cnt, 12);
        check("load_first_go_cycle", first_go_cyc, (1 << SETTLE_LOG2) + 2);
        check("load_word0", word_log[0], 24'h341E00);
        check("load_word11", word_log[11], 24'h341201);
        wait_idle(1000, "collapse_idle");
        check("collapse_go_count", go_cnt, 14);
        check("collapse_word12", word_log[12], 24'h340479);
        check("collapse_word13", word_log[13], 24'h340679);
        check("collapse_done", cfg_done, 1);

        // Volume update after DONE.
        vol = 7'h50;
        repeat (3) @(negedge CLOCK);
        push_range(9, 10, 7'h50);
        pulse_update();
        wait_idle(1000, "update_idle");
        check("update_go_count", go_cnt, 16);
        check("update_word_reg2", word_log[14], 24'h340450);
        check("update_word_reg3", word_log[15], 24'h340650);
        check("update_done", cfg_done, 1);
        check("update_error", cfg_error, 0);
        check("update_busy", cfg_busy, 0);

`ifndef CODEC_CFG_RETRY_EN
        // NACK at index 7 stops the sequence for good.
        start_run();
        nack_left[7] = 1;
        push_range(0, 7, 7'h50);
        wait_status(1'b1, 3000, "nack_error_seen");
        check("nack_err_index", err_index, 7);
        check("nack_go_count", go_cnt, 8);
        check("nack_done", cfg_done, 0);
        check("nack_busy", cfg_busy, 0);
        pulse_update();
        repeat (100) @(negedge CLOCK);
        check("nack_no_more_go", go_cnt, 8);
        check("nack_error_sticky", cfg_error, 1);

        // Silent serialiser: timeout 64 cycles after the go, ERROR the cycle after FAIL.
        start_run();
        ser_silent = 1'b1;
        push_range(0, 0, 7'h50);
        wait_go(1, 500, "tmo_go_seen");
        go_edge = first_go_cyc;
        while (cyc < go_edge + TIMEOUT && RESET) @(negedge CLOCK);
        check("tmo_error_before", cfg_error, 0);
        @(negedge CLOCK);
        check("tmo_error_at", cfg_error, 1);
        check("tmo_err_index", err_index, 0);
        check("tmo_go_count", go_cnt, 1);
        check("tmo_busy", cfg_busy, 0);
`else
        // Index 4 NACKs twice, then ACKs: three issues of that word.
        start_run();
        nack_left[4] = 2;
        push_range(0, 4, 7'h50);
        push_range(4, 4, 7'h50);
        push_range(4, 4, 7'h50);
        push_range(5, 11, 7'h50);
        wait_idle(3000, "retry_idle");
        n_w4 = 0;
        foreach (word_log[i]) if (word_log[i] == 24'h340812) n_w4++;
        check("retry_idx4_issues", n_w4, 3);
        check("retry_go_count", go_cnt, 14);
        check("retry_done", cfg_done, 1);
        check("retry_error", cfg_error, 0);

        // Silent serialiser: every retry times out, then ERROR.
        start_run();
        ser_silent = 1'b1;
        for (int r = 0; r <= MAX_RETRY; r++) push_range(0, 0, 7'h50);
        wait_status(1'b1, 2000, "tmo_error_seen");
        check("tmo_err_index", err_index, 0);
        check("tmo_go_count", go_cnt, MAX_RETRY + 1);
        check("tmo_busy", cfg_busy, 0);
        check("tmo_done", cfg_done, 0);
`endif

        // Reset while waiting on index 5, then a clean restart with a stray done in SETTLE.
        vol = 7'h79;
        start_run();
        push_range(0, 11, 7'h79);
        wait_go(6, 1000, "abort_go6");
        repeat (3) @(negedge CLOCK);
        #1 RESET = 1'b0;
        #1;
        check("abort_go", bus.i2c_go, 0);
        check("abort_data", bus.i2c_data, 0);
        check("abort_busy", cfg_busy, 0);
        check("abort_done", cfg_done, 0);
        check("abort_error", cfg_error, 0);
        check("abort_err_index", err_index, 0);
        start_run();
        push_range(0, 11, 7'h79);
        repeat (5) @(negedge CLOCK);
        stray_req = 1'b1;
        wait_idle(2000, "restart_idle");
        check("restart_first_go_cycle", first_go_cyc, (1 << SETTLE_LOG2) + 2);
        check("restart_go_count", go_cnt, 12);
        check("restart_word5", word_log[5], 24'h340A00);
        check("restart_done", cfg_done, 1);
        check("restart_error", cfg_error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
